wb_write_queue: RTL and testbench

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

---
 rtl/wb_write_queue.sv | 138 +++++++++++++
 tb/tb_wb_write_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
`timescale 1ns/1ps
// Writeback queue: merges load and ALU results into one register-file write port.
// Latency: an accepted entry is visible on WE3/A3/WD3 the cycle after acceptance; forwarding is combinational.
// Backpressure: alu_ready drops when only one slot is free and the load side claims it; zero-register requests are always accepted and dropped.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   mem_valid/addr/data/ready    load-result request channel (older of a same-cycle pair)
//   alu_valid/addr/data/ready    ALU-result request channel (younger of a same-cycle pair)
//   WE3, A3, WD3                 register file write port, driven from the head entry
//   fwd_addr, fwd_hit, fwd_data  decode-stage forwarding lookup over pending entries
//   count                        number of pending entries, 0..DEPTH

module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [4:0]  mem_addr,
  input  logic [17:0] mem_data,
  output logic        mem_ready,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [17:0] alu_data,
  output logic        alu_ready,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [17:0] WD3,
  input  logic [4:0]  fwd_addr,
  output logic        fwd_hit,
  output logic [17:0] fwd_data,
  output logic [4:0]  count
);

  localparam int PW = $clog2(DEPTH);
  typedef logic [PW-1:0] ptr_t;

  // Queue control state (reset) and entry storage (not reset).
  ptr_t        head_q, head_d;
  ptr_t        tail_q, tail_d;
  logic [4:0]  count_q, count_d;
  logic [4:0]  addr_q [DEPTH];
  logic [4:0]  addr_d [DEPTH];
  logic [17:0] data_q [DEPTH];
  logic [17:0] data_d [DEPTH];

  // Per-cycle handshake decisions.
  logic        nonempty;
  logic        pop;
  logic [5:0]  free;
  logic        mem_enq;
  logic        alu_enq;
  logic [1:0]  n_enq;
  ptr_t        alu_slot;
  ptr_t        fwd_idx;

  // Acceptance. The head always retires this cycle when the queue is
  // non-empty, so its slot counts as free for a same-cycle enqueue.
  always_comb begin
    nonempty  = (count_q != 5'd0);
    pop       = nonempty;
    free      = 6'(DEPTH) - {1'b0, count_q} + {5'd0, nonempty};
    mem_ready = (mem_addr == 5'd0) || (free >= 6'd1);
    // With one free slot the load side has priority, since it is the older
    // result and must land in the queue ahead of the ALU result.
    alu_ready = (alu_addr == 5'd0) || (free >= 6'd2) ||
                ((free == 6'd1) && (!mem_valid || (mem_addr == 5'd0)));
    // Writes to r0 are handshaken but discarded; nothing is queued in reset.
    mem_enq   = !rst && mem_valid && mem_ready && (mem_addr != 5'd0);
    alu_enq   = !rst && alu_valid && alu_ready && (alu_addr != 5'd0);
    n_enq     = {1'b0, mem_enq} + {1'b0, alu_enq};
  end

  // Next-state for pointers, occupancy and storage. The ALU entry goes one
  // slot behind the load entry when both are enqueued together.
  always_comb begin
    head_d   = head_q + ptr_t'(pop);
    tail_d   = tail_q + ptr_t'(n_enq);
    alu_slot = tail_q + ptr_t'(mem_enq);
    count_d  = count_q - 5'(pop) + 5'(n_enq);
    addr_d   = addr_q;
    data_d   = data_q;
    if (mem_enq) begin
      addr_d[tail_q] = mem_addr;
      data_d[tail_q] = mem_data;
    end
    if (alu_enq) begin
      addr_d[alu_slot] = alu_addr;
      data_d[alu_slot] = alu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage contents are qualified by count, so they need no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Register file port: head entry, forced to zero when nothing is pending.
  always_comb begin
    WE3 = nonempty;
    A3  = nonempty ? addr_q[head_q] : 5'd0;
    WD3 = nonempty ? data_q[head_q] : 18'd0;
  end

  // Forwarding scans oldest to youngest so the last match wins. The head is
  // included: its register file write only takes effect at the next edge.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 18'd0;
    fwd_idx  = '0;
    if (fwd_addr != 5'd0) begin
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = head_q + ptr_t'(i);
        if ((5'(i) < count_q) && (addr_q[fwd_idx] == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[fwd_idx];
        end
      end
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_wb_write_queue.sv
`timescale 1ns/1ps
// Bench for wb_write_queue: directed vector table plus hand-written sequences
// for wrap-around ordering and asynchronous reset mid-stream.
module tb_wb_write_queue;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic [4:0]  mem_addr;
  logic [17:0] mem_data;
  logic        mem_ready;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [17:0] alu_data;
  logic        alu_ready;
  logic        WE3;
  logic [4:0]  A3;
  logic [17:0] WD3;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [17:0] fwd_data;
  logic [4:0]  count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [22:0] wlog [$];

  wb_write_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mv;
    logic [4:0]  ma;
    logic [17:0] md;
    logic        av;
    logic [4:0]  aa;
    logic [17:0] ad;
    logic [4:0]  fa;
    logic        emr;
    logic        ear;
    logic        ewe;
    logic [4:0]  ea3;
    logic [17:0] ewd;
    logic        ehit;
    logic [17:0] efd;
    logic [4:0]  ecnt;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mkv(
    input logic mv, input logic [4:0] ma, input logic [17:0] md,
    input logic av, input logic [4:0] aa, input logic [17:0] ad,
    input logic [4:0] fa,
    input logic emr, input logic ear, input logic ewe,
    input logic [4:0] ea3, input logic [17:0] ewd,
    input logic ehit, input logic [17:0] efd, input logic [4:0] ecnt);
    vec_t v;
    v.mv = mv; v.ma = ma; v.md = md;
    v.av = av; v.aa = aa; v.ad = ad; v.fa = fa;
    v.emr = emr; v.ear = ear; v.ewe = ewe; v.ea3 = ea3; v.ewd = ewd;
    v.ehit = ehit; v.efd = efd; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Let combinational outputs settle, then record any register file write.
  task automatic settle();
    #1;
    if (WE3 === 1'b1) wlog.push_back({A3, WD3});
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_addr = 5'd0; mem_data = 18'd0;
    alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 18'd0;
  endtask

  initial begin
    //           mv ma     md          av aa     ad          fa     mr ar we a3     wd          hit fd          cnt
    vecs[0]  = mkv(0, 5'd0,  18'h0,     0, 5'd0,  18'h0,     5'd0,  1, 1, 0, 5'd0,  18'h0,     0, 18'h0,     5'd0);
    vecs[1]  = mkv(1, 5'd5,  18'h00ABC, 0, 5'd0,  18'h0,     5'd5,  1, 1, 0, 5'd0,  18'h0,     0, 18'h0,     5'd0);
    vecs[2]  = mkv(0, 5'd0,  18'h0,     0, 5'd0,  18'h0,     5'd5,  1, 1, 1, 5'd5,  18'h00ABC, 1, 18'h00ABC, 5'd1);
    vecs[3]  = mkv(0, 5'd0,  18'h0,     0, 5'd0,  18'h0,     5'd5,  1, 1, 0, 5'd0,  18'h0,     0, 18'h0,     5'd0);
    vecs[4]  = mkv(1, 5'd3,  18'h00111, 1, 5'd3,  18'h00222, 5'd3,  1, 1, 0, 5'd0,  18'h0,     0, 18'h0,     5'd0);
    vecs[5]  = mkv(0, 5'd0,  18'h0,     0, 5'd0,  18'h0,     5'd3,  1, 1, 1, 5'd3,  18'h00111, 1, 18'h00222, 5'd2);
    vecs[6]  = mkv(0, 5'd0,  18'h0,     0, 5'd0,  18'h0,     5'd3,  1, 1, 1, 5'd3,  18'h00222, 1, 18'h00222, 5'd1);
    vecs[7]  = mkv(1, 5'd1,  18'h00001, 1, 5'd2,  18'h00002, 5'd0,  1, 1, 0, 5'd0,  18'h0,     0, 18'h0,     5'd0);
    vecs[8]  = mkv(1, 5'd3,  18'h00003, 1, 5'd4,  18'h00004, 5'd0,  1, 1, 1, 5'd1,  18'h00001, 0, 18'h0,     5'd2);
    vecs[9]  = mkv(1, 5'd5,  18'h00005, 1, 5'd6,  18'h00006, 5'd0,  1, 1, 1, 5'd2,  18'h00002, 0, 18'h0,     5'd3);
    vecs[10] = mkv(1, 5'd7,  18'h00007, 1, 5'd8,  18'h00008, 5'd0,  1, 0, 1, 5'd3,  18'h00003, 0, 18'h0,     5'd4);
    vecs[11] = mkv(1, 5'd9,  18'h00009, 1, 5'd8,  18'h00008, 5'd6,  1, 0, 1, 5'd4,  18'h00004, 1, 18'h00006, 5'd4);
    vecs[12] = mkv(0, 5'd0,  18'h0,     1, 5'd8,  18'h00008, 5'd9,  1, 1, 1, 5'd5,  18'h00005, 1, 18'h00009, 5'd4);
    vecs[13] = mkv(0, 5'd0,  18'h0,     1, 5'd0,  18'h3FFFF, 5'd0,  1, 1, 1, 5'd6,  18'h00006, 0, 18'h0,     5'd4);
    vecs[14] = mkv(0, 5'd0,  18'h0,     0, 5'd0,  18'h0,     5'd0,  1, 1, 1, 5'd7,  18'h00007, 0, 18'h0,     5'd3);
    vecs[15] = mkv(0, 5'd0,  18'h0,     0, 5'd0,  18'h0,     5'd8,  1, 1, 1, 5'd9,  18'h00009, 1, 18'h00008, 5'd2);
    vecs[16] = mkv(0, 5'd0,  18'h0,     0, 5'd0,  18'h0,     5'd9,  1, 1, 1, 5'd8,  18'h00008, 0, 18'h0,     5'd1);
    vecs[17] = mkv(0, 5'd0,  18'h0,     0, 5'd0,  18'h0,     5'd0,  1, 1, 0, 5'd0,  18'h0,     0, 18'h0,     5'd0);
    vecs[18] = mkv(1, 5'd0,  18'h3FFFF, 1, 5'd0,  18'h3FFFF, 5'd0,  1, 1, 0, 5'd0,  18'h0,     0, 18'h0,     5'd0);
    vecs[19] = mkv(0, 5'd0,  18'h0,     0, 5'd0,  18'h0,     5'd0,  1, 1, 0, 5'd0,  18'h0,     0, 18'h0,     5'd0);

    rst = 1'b1;
    fwd_addr = 5'd0;
    idle_inputs();

    // Reset state, held across clock edges.
    next_edge();
    next_edge();
    chk("rst.we3",   32'(WE3),      32'd0);
    chk("rst.a3",    32'(A3),       32'd0);
    chk("rst.wd3",   32'(WD3),      32'd0);
    chk("rst.count", 32'(count),    32'd0);
    chk("rst.hit",   32'(fwd_hit),  32'd0);
    chk("rst.fdata", 32'(fwd_data), 32'd0);
    rst = 1'b0;

    // Directed vector table: expectations are for the cycle the inputs are applied.
    for (int i = 0; i < NV; i++) begin
      mem_valid = vecs[i].mv; mem_addr = vecs[i].ma; mem_data = vecs[i].md;
      alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = vecs[i].ad;
      fwd_addr  = vecs[i].fa;
      settle();
      chk($sformatf("v%0d.mem_ready", i), 32'(mem_ready), 32'(vecs[i].emr));
      chk($sformatf("v%0d.alu_ready", i), 32'(alu_ready), 32'(vecs[i].ear));
      chk($sformatf("v%0d.we3", i),       32'(WE3),       32'(vecs[i].ewe));
      chk($sformatf("v%0d.a3", i),        32'(A3),        32'(vecs[i].ea3));
      chk($sformatf("v%0d.wd3", i),       32'(WD3),       32'(vecs[i].ewd));
      chk($sformatf("v%0d.fwd_hit", i),   32'(fwd_hit),   32'(vecs[i].ehit));
      chk($sformatf("v%0d.fwd_data", i),  32'(fwd_data),  32'(vecs[i].efd));
      chk($sformatf("v%0d.count", i),     32'(count),     32'(vecs[i].ecnt));
      next_edge();
    end

    // Wrap-around: ten back-to-back single writes, addresses 1..10.
    idle_inputs();
    fwd_addr = 5'd0;
    wlog.delete();
    for (int k = 1; k <= 10; k++) begin
      mem_valid = 1'b1;
      mem_addr  = 5'(k);
      mem_data  = 18'h00100 + 18'(k);
      settle();
      chk($sformatf("wrap%0d.cnt_le2", k), 32'(count <= 5'd2), 32'd1);
      next_edge();
    end
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      settle();
      next_edge();
    end
    chk("wrap.nwrites", 32'(wlog.size()), 32'd10);
    for (int k = 1; k <= 10; k++) begin
      logic [22:0] exp_w;
      exp_w = {5'(k), 18'h00100 + 18'(k)};
      if (wlog.size() >= k) chk($sformatf("wrap.write%0d", k), 32'(wlog[k-1]), 32'(exp_w));
    end

    // Asynchronous reset with three entries pending.
    mem_valid = 1'b1; mem_addr = 5'd1; mem_data = 18'h00011;
    alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 18'h00022;
    next_edge();
    mem_addr = 5'd3; mem_data = 18'h00033;
    alu_addr = 5'd4; alu_data = 18'h00044;
    next_edge();
    idle_inputs();
    fwd_addr = 5'd3;
    #1;
    chk("arst.pre_count", 32'(count),   32'd3);
    chk("arst.pre_hit",   32'(fwd_hit), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst.we3",   32'(WE3),      32'd0);
    chk("arst.a3",    32'(A3),       32'd0);
    chk("arst.count", 32'(count),    32'd0);
    chk("arst.hit",   32'(fwd_hit),  32'd0);
    chk("arst.fdata", 32'(fwd_data), 32'd0);
    // A request offered during reset is handshaken but never queued.
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 18'h00077;
    #1;
    chk("arst.mem_ready", 32'(mem_ready), 32'd1);
    wlog.delete();
    next_edge();
    chk("arst.count_edge", 32'(count), 32'd0);
    rst = 1'b0;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      settle();
      next_edge();
    end
    chk("arst.no_writes", 32'(wlog.size()), 32'd0);
    chk("arst.post_count", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
